// File: rtl/calc_pkg.sv
// Shared types and constants for the hex calculator operand entry path.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OFFER = 2'd2
  } entry_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] MAX_DIGIT_DEFAULT = 4'hB;

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> synchronizer -> debouncer -> one-cycle press pulse.
// CALC_ENTRY_DEBOUNCE_EN selects the full stable-count filter; otherwise sync + edge detect only.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

`ifdef CALC_ENTRY_DEBOUNCE_EN
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES);
`else
  // Terminal count of zero makes the filter accept any change on the first sample.
  localparam logic [CW-1:0] TERM = '0;
`endif

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    // Stays disarmed until the key is seen released, so a key held through reset never fires.
    armed_d  = armed_q | sync2_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERM) begin
        stable_d = sync2_q;
        press_d  = stable_q & armed_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b1;
      armed_q  <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Operand entry controller: collects A, B and an opcode from keys/switches and offers them once.
// Key filtering depth is controlled by CALC_ENTRY_DEBOUNCE_EN inside key_debounce.
//
// state   | meaning
// S_A     | digits shift into operand A
// S_B     | digits shift into operand B
// S_OFFER | A/B/OP held, OUT_VALID high until accepted or cleared
module calc_operand_entry
  import calc_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [3:0] MAX_DIGIT       = MAX_DIGIT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       KEY_DIGIT,
  input  logic       KEY_NEXT,
  input  logic       KEY_CLEAR,
  input  logic [3:0] SW_VAL,
  input  logic [1:0] SW_OP,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic [1:0] OP,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       ERR,
  output logic [1:0] ENTRY_STATE
);

  logic digit_p, next_p, clear_p;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_digit (
    .clk(CLOCK_50), .rst_n(RST_N), .key_n(KEY_DIGIT), .press(digit_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk(CLOCK_50), .rst_n(RST_N), .key_n(KEY_NEXT), .press(next_p)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk(CLOCK_50), .rst_n(RST_N), .key_n(KEY_CLEAR), .press(clear_p)
  );

  entry_state_e state_q, state_d;
  logic [7:0]   a_q, a_d, b_q, b_d;
  logic [1:0]   op_q, op_d;
  logic [1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic         err_q, err_d;
  logic         digit_bad;

  assign digit_bad = (SW_VAL > MAX_DIGIT);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    err_d   = 1'b0;
    if (clear_p) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (digit_p) begin
            if (digit_bad || cnt_a_q == 2'd2) begin
              err_d = 1'b1;
            end else begin
              a_d     = {a_q[3:0], SW_VAL};
              cnt_a_d = cnt_a_q + 2'd1;
            end
          end else if (next_p) begin
            state_d = S_B;
          end
        end
        S_B: begin
          if (digit_p) begin
            if (digit_bad || cnt_b_q == 2'd2) begin
              err_d = 1'b1;
            end else begin
              b_d     = {b_q[3:0], SW_VAL};
              cnt_b_d = cnt_b_q + 2'd1;
            end
          end else if (next_p) begin
            // Refuse to offer a division by zero.
            if (SW_OP == OP_DIV && b_q == 8'h00) begin
              err_d = 1'b1;
            end else begin
              op_d    = SW_OP;
              state_d = S_OFFER;
            end
          end
        end
        S_OFFER: begin
          if (OUT_READY) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      err_q   <= err_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign OP          = op_q;
  assign ERR         = err_q;
  assign OUT_VALID   = (state_q == S_OFFER);
  assign ENTRY_STATE = state_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: per-scenario tasks plus a scoreboard on the output handshake.
module tb_calc_operand_entry;

  logic       CLOCK_50 = 1'b0;
  logic       RST_N = 1'b0;
  logic       KEY_DIGIT = 1'b1, KEY_NEXT = 1'b1, KEY_CLEAR = 1'b1;
  logic [3:0] SW_VAL = 4'h0;
  logic [1:0] SW_OP = 2'b00;
  logic       OUT_READY = 1'b0;
  logic [7:0] A, B;
  logic [1:0] OP;
  logic       OUT_VALID, ERR;
  logic [1:0] ENTRY_STATE;

  calc_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .RST_N(RST_N), .KEY_DIGIT(KEY_DIGIT), .KEY_NEXT(KEY_NEXT),
    .KEY_CLEAR(KEY_CLEAR), .SW_VAL(SW_VAL), .SW_OP(SW_OP), .A(A), .B(B), .OP(OP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .ERR(ERR), .ENTRY_STATE(ENTRY_STATE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_exp;
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   xfer_cnt = 0;
  logic err_prev = 1'b0;

  always @(negedge CLOCK_50) begin
    if (ERR) begin
      err_cnt++;
      checks++;
      if (err_prev) begin
        errors++;
        $display("FAIL err_width: ERR high in consecutive cycles, required one-cycle pulse");
      end
    end
    err_prev = ERR;
    if (RST_N && OUT_VALID && OUT_READY) begin
      checks++;
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: A=%h B=%h OP=%b offered with no expectation", A, B, OP);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({A, B, OP} !== mon_exp) begin
          errors++;
          $display("FAIL xfer_data: got A=%h B=%h OP=%b, expected A=%h B=%h OP=%b",
                   A, B, OP, mon_exp.a, mon_exp.b, mon_exp.op);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press(input bit d, input bit n, input bit c);
    tick(1);
    KEY_DIGIT = ~d;
    KEY_NEXT  = ~n;
    KEY_CLEAR = ~c;
    tick(10);
    KEY_DIGIT = 1'b1;
    KEY_NEXT  = 1'b1;
    KEY_CLEAR = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    int e0;
    RST_N = 1'b0;
    SW_VAL = 4'h5;
    KEY_DIGIT = 1'b0;
    tick(3);
    checks++;
    if ({A, B, OP, OUT_VALID, ERR, ENTRY_STATE} !== 21'd0) begin
      errors++;
      $display("FAIL reset_values: A=%h B=%h OP=%b V=%b ERR=%b ST=%0d, required all 0",
               A, B, OP, OUT_VALID, ERR, ENTRY_STATE);
    end
    e0 = err_cnt;
    RST_N = 1'b1;
    tick(15);
    checks++;
    if (A !== 8'h00 || err_cnt != e0) begin
      errors++;
      $display("FAIL reset_held_key: A=%h errs=%0d, required A=00 errs=0", A, err_cnt - e0);
    end
    KEY_DIGIT = 1'b1;
    tick(15);
  endtask

  task automatic test_basic();
    int x0;
    SW_VAL = 4'h1; press(1, 0, 0);
    SW_VAL = 4'hA; press(1, 0, 0);
    press(0, 1, 0);
    SW_VAL = 4'h0; press(1, 0, 0);
    SW_VAL = 4'h3; press(1, 0, 0);
    SW_OP = 2'b10; press(0, 1, 0);
    checks++;
    if (OUT_VALID !== 1'b1 || A !== 8'h1A || B !== 8'h03 || OP !== 2'b10 || ENTRY_STATE !== 2'd2) begin
      errors++;
      $display("FAIL basic_offer: V=%b A=%h B=%h OP=%b ST=%0d, required V=1 A=1a B=03 OP=10 ST=2",
               OUT_VALID, A, B, OP, ENTRY_STATE);
    end
    x0 = xfer_cnt;
    exp_q.push_back('{a: 8'h1A, b: 8'h03, op: 2'b10});
    OUT_READY = 1'b1;
    tick(1);
    checks++;
    if (OUT_VALID !== 1'b0 || A !== 8'h00 || B !== 8'h00 || ENTRY_STATE !== 2'd0 || xfer_cnt != x0 + 1) begin
      errors++;
      $display("FAIL basic_accept: V=%b A=%h B=%h ST=%0d xfers=%0d, required V=0 A=00 B=00 ST=0 xfers=1",
               OUT_VALID, A, B, ENTRY_STATE, xfer_cnt - x0);
    end
    OUT_READY = 1'b0;
  endtask

  task automatic test_bad_digit();
    int e0;
    e0 = err_cnt;
    SW_VAL = 4'hC; press(1, 0, 0);
    checks++;
    if (err_cnt != e0 + 1 || A !== 8'h00) begin
      errors++;
      $display("FAIL bad_digit: errs=%0d A=%h, required errs=1 A=00", err_cnt - e0, A);
    end
    SW_VAL = 4'h5; press(1, 0, 0);
    SW_VAL = 4'h7; press(1, 0, 0);
    e0 = err_cnt;
    SW_VAL = 4'h9; press(1, 0, 0);
    checks++;
    if (err_cnt != e0 + 1 || A !== 8'h57) begin
      errors++;
      $display("FAIL third_digit: errs=%0d A=%h, required errs=1 A=57", err_cnt - e0, A);
    end
    press(0, 0, 1);
  endtask

  task automatic test_div_zero();
    int e0;
    SW_VAL = 4'h2; press(1, 0, 0);
    press(0, 1, 0);
    SW_OP = 2'b11;
    e0 = err_cnt;
    press(0, 1, 0);
    checks++;
    if (err_cnt != e0 + 1 || ENTRY_STATE !== 2'd1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL div_zero: errs=%0d ST=%0d V=%b, required errs=1 ST=1 V=0",
               err_cnt - e0, ENTRY_STATE, OUT_VALID);
    end
    SW_OP = 2'b00;
    press(0, 1, 0);
    exp_q.push_back('{a: 8'h02, b: 8'h00, op: 2'b00});
    OUT_READY = 1'b1;
    tick(1);
    OUT_READY = 1'b0;
  endtask

  task automatic test_offer_hold();
    int e0;
    SW_VAL = 4'h6; press(1, 0, 0);
    press(0, 1, 0);
    SW_VAL = 4'h9; press(1, 0, 0);
    SW_OP = 2'b01; press(0, 1, 0);
    tick(10);
    e0 = err_cnt;
    SW_VAL = 4'h5; press(1, 0, 0);
    press(0, 1, 0);
    checks++;
    if (OUT_VALID !== 1'b1 || A !== 8'h06 || B !== 8'h09 || OP !== 2'b01 || err_cnt != e0) begin
      errors++;
      $display("FAIL offer_hold: V=%b A=%h B=%h OP=%b errs=%0d, required V=1 A=06 B=09 OP=01 errs=0",
               OUT_VALID, A, B, OP, err_cnt - e0);
    end
    press(0, 0, 1);
    checks++;
    if (OUT_VALID !== 1'b0 || ENTRY_STATE !== 2'd0 || A !== 8'h00 || OP !== 2'b00) begin
      errors++;
      $display("FAIL offer_clear: V=%b ST=%0d A=%h OP=%b, required V=0 ST=0 A=00 OP=00",
               OUT_VALID, ENTRY_STATE, A, OP);
    end
  endtask

  task automatic test_priority();
    int e0;
    e0 = err_cnt;
    SW_VAL = 4'h3; press(1, 1, 0);
    checks++;
    if (A !== 8'h03 || ENTRY_STATE !== 2'd0 || err_cnt != e0) begin
      errors++;
      $display("FAIL digit_over_next: A=%h ST=%0d errs=%0d, required A=03 ST=0 errs=0",
               A, ENTRY_STATE, err_cnt - e0);
    end
    SW_VAL = 4'h7; press(1, 0, 1);
    checks++;
    if (A !== 8'h00 || ENTRY_STATE !== 2'd0) begin
      errors++;
      $display("FAIL clear_over_digit: A=%h ST=%0d, required A=00 ST=0", A, ENTRY_STATE);
    end
  endtask

  task automatic test_ready_early();
    int x0;
    SW_VAL = 4'h4; press(1, 0, 0);
    press(0, 1, 0);
    SW_VAL = 4'h2; press(1, 0, 0);
    SW_OP = 2'b01;
    OUT_READY = 1'b1;
    x0 = xfer_cnt;
    exp_q.push_back('{a: 8'h04, b: 8'h02, op: 2'b01});
    press(0, 1, 0);
    checks++;
    if (xfer_cnt != x0 + 1 || OUT_VALID !== 1'b0 || ENTRY_STATE !== 2'd0 || A !== 8'h00) begin
      errors++;
      $display("FAIL ready_early: xfers=%0d V=%b ST=%0d A=%h, required xfers=1 V=0 ST=0 A=00",
               xfer_cnt - x0, OUT_VALID, ENTRY_STATE, A);
    end
    OUT_READY = 1'b0;
  endtask

`ifdef CALC_ENTRY_DEBOUNCE_EN
  task automatic test_bounce();
    int e0;
    e0 = err_cnt;
    SW_VAL = 4'h2;
    for (int i = 0; i < 4; i++) begin
      KEY_DIGIT = 1'b0; tick(3);
      KEY_DIGIT = 1'b1; tick(3);
    end
    tick(12);
    checks++;
    if (A !== 8'h00 || err_cnt != e0) begin
      errors++;
      $display("FAIL bounce: A=%h errs=%0d, required A=00 errs=0", A, err_cnt - e0);
    end
  endtask
`endif

  task automatic test_reset_mid();
    SW_VAL = 4'h8; press(1, 0, 0);
    press(0, 1, 0);
    SW_VAL = 4'h1; press(1, 0, 0);
    SW_OP = 2'b11; press(0, 1, 0);
    RST_N = 1'b0;
    tick(1);
    checks++;
    if ({A, B, OP, OUT_VALID, ERR, ENTRY_STATE} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid: A=%h B=%h OP=%b V=%b ERR=%b ST=%0d, required all 0",
               A, B, OP, OUT_VALID, ERR, ENTRY_STATE);
    end
    RST_N = 1'b1;
    tick(15);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_digit();
    test_div_zero();
    test_offer_hold();
    test_priority();
    test_ready_early();
`ifdef CALC_ENTRY_DEBOUNCE_EN
    test_bounce();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected transfers pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_operand_entry.md
# calc_operand_entry

Push-button operand entry controller for the two-operand hex calculator; the input-side initiator that feeds the calculator core. The user enters hex digits on four slide switches and commits each with a key. After both 8-bit operands and an opcode are collected, the block offers them once over a valid/ready handshake. Sits between the DE2 KEY/SW pins and the calculator core, which consumes A, B and OP.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: stable-level count before a key press is accepted (20 ms at 50 MHz)
- MAX_DIGIT, 4'hB: largest accepted digit value; larger values are rejected as undefined
- CLOCK_50  in  1  system clock, all logic rising-edge
- RST_N  in  1  reset, synchronous, active-low
- KEY_DIGIT  in  1  active-low raw push button, commits SW_VAL as the next digit
- KEY_NEXT  in  1  active-low raw push button, advances A→B→offer
- KEY_CLEAR  in  1  active-low raw push button, aborts entry
- SW_VAL  in  4  digit value
- SW_OP  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div
- A  out  8  operand A
- B  out  8  operand B
- OP  out  2  latched opcode
- OUT_VALID  out  1  operands offered
- OUT_READY  in  1  core accepts
- ERR  out  1  one-cycle pulse on a rejected action
- ENTRY_STATE  out  2  current FSM state, for LEDR

## Operation
- Each key passes through a 2-flop synchronizer and the debouncer, then produces a one-cycle press pulse on the accepted high→low transition. Release produces no pulse.
- States:
  - S_A (2'd0): digits shift into A.
  - S_B (2'd1): digits shift into B.
  - S_OFFER (2'd2): OUT_VALID=1.
- Digit press in S_A/S_B: if SW_VAL > MAX_DIGIT, ERR and no change. Otherwise operand <= {operand[3:0], SW_VAL}. The per-operand digit counter (0..2) increments.
- A third digit on the same operand: ERR, operand unchanged.
- NEXT in S_A → S_B. Zero digits entered means the operand is 0.
- NEXT in S_B: latch OP <= SW_OP, then → S_OFFER.
- Exception: if SW_OP==2'b11 and B==0, ERR and stay in S_B (division by zero refused).
- S_OFFER:
  - A, B and OP are held stable.
  - Digit and NEXT presses are ignored, with no ERR.
  - OUT_VALID && OUT_READY → A=0, B=0, counters=0, → S_A.
- CLEAR in any state: A=B=0, OP=0, counters=0, OUT_VALID=0, → S_A. CLEAR is the only legal way to withdraw an offer.
- Pulses in the same cycle: CLEAR > DIGIT > NEXT. Lower-priority pulses are dropped without ERR.
- The state encoding 2'd3 is unreachable and recovers to S_A on the next clock.

## Timing
- Reset values: A=0, B=0, OP=0, OUT_VALID=0, ERR=0, ENTRY_STATE=S_A. Debouncer stable levels=1 (released) with counters at 0. No press pulse follows reset release while keys are held.
- Press pulse latency from the pin edge: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Outputs update one cycle after the press pulse. OUT_VALID rises in the same cycle ENTRY_STATE becomes S_OFFER.
- Handshake completes on a clock edge with both OUT_VALID and OUT_READY high. OUT_VALID is low the following cycle.
- OUT_READY held high before OUT_VALID is legal, and completes in the first offer cycle.
- Reset asserted mid-entry or mid-offer returns everything to reset values on that edge.

## Configuration
- CALC_ENTRY_DEBOUNCE_EN:
  - Defined: full DEBOUNCE_CYCLES counter debouncer.
  - Undefined: synchronizer plus edge detect only. Press latency is 3 cycles and DEBOUNCE_CYCLES is ignored. Intended for fast simulation.

## Structure
- Package calc_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV (2'b00..2'b11)
  - state constants S_A/S_B/S_OFFER
  - the MAX_DIGIT default
- One sub-module, key_debounce: synchronizer, counter and press-pulse generator. It is instantiated three times, and the macro applies inside it.

## Test plan
- Bench uses DEBOUNCE_CYCLES=4.
- Digits 1, A, NEXT, digits 0, 3, SW_OP=10, NEXT → OUT_VALID=1, A=8'h1A, B=8'h03, OP=2'b10. With OUT_READY=1 one cycle later, OUT_VALID=0 and A=B=0.
- SW_VAL=4'hC on digit press in S_A → ERR pulses for one cycle and A is unchanged. A third digit after 5, 7 → ERR, A=8'h57.
- B entered as 0, SW_OP=11, NEXT → ERR, ENTRY_STATE stays S_B, OUT_VALID=0.
- In S_OFFER, hold OUT_READY=0 for 10 cycles and press a digit → A/B/OP stable, no ERR. Then CLEAR → OUT_VALID=0, ENTRY_STATE=S_A.
- DIGIT and NEXT pulses in the same cycle in S_A → digit accepted, state stays S_A. CLEAR with DIGIT → A=0.
- Bounce (3-cycle low glitches) on KEY_DIGIT with the macro defined → no digit accepted. RST_N low mid-entry → all reset values next edge.
